muldiv_sequencer: RTL and testbench

Controller that sequences the multiplier and divider units of the multicycle CPU and their HI/LO register writes on behalf of the main control FSM. It accepts a one-cycle mult or div request, pulses the unit's start line, and waits for its end flag. It then steers the HI/LO input muxes and asserts the HI/LO write enables for exactly one cycle. It reports completion, divide-by-zero and timeout back to the main control FSM, which stalls while busy is high.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_wait_cnt.sv | 42 ++++
 rtl/muldiv_sequencer.sv | 150 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding, default timeout,
// HI/LO mux select encodings and exception cause codes. Also used by the main control FSM.
package muldiv_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;
  localparam int unsigned CNT_W_DEFAULT          = 7;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StWaitMult = 3'd2,
    StWaitDiv  = 3'd3,
    StWrite    = 3'd4,
    StDone     = 3'd5,
    StExc      = 3'd6
  } muldiv_state_e;

  // HI/LO input mux select
  localparam logic SEL_MULT = 1'b0;
  localparam logic SEL_DIV  = 1'b1;

  // Exception cause latched on entry to StExc
  localparam logic CAUSE_TIMEOUT  = 1'b0;
  localparam logic CAUSE_DIV_ZERO = 1'b1;

endpackage

// File: rtl/muldiv_wait_cnt.sv
// Wait counter for the multiply/divide sequencer.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   clr_i  - synchronous clear (wins over enable)
//   en_i   - count enable
//   tc_o   - high while the count equals TIMEOUT_CYCLES-1
module muldiv_wait_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TcVal = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the multiplier/divider units and the HI/LO register writes for the main control FSM.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   req, op_mult, op_div  - one-cycle request and operation select (sampled in IDLE only)
//   flush                 - synchronous abort to IDLE
//   mult_end, div_end     - unit result valid flags
//   div_zero              - divider zero-divisor flag
//   start_mult, start_div - one-cycle unit start pulses
//   hilo_sel              - HI/LO mux select (0 multiplier, 1 divider), registered
//   wr_high, wr_low       - HI/LO load enables
//   busy                  - high outside IDLE
//   done, div_zero_exc, timeout_exc - one-cycle completion/exception pulses
//   cur_state             - current state encoding
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       op_mult,
  input  logic       op_div,
  input  logic       flush,
  input  logic       mult_end,
  input  logic       div_end,
  input  logic       div_zero,
  output logic       start_mult,
  output logic       start_div,
  output logic       hilo_sel,
  output logic       wr_high,
  output logic       wr_low,
  output logic       busy,
  output logic       done,
  output logic       div_zero_exc,
  output logic       timeout_exc,
  output logic [2:0] cur_state
);

  muldiv_state_e state_q, state_d;
  logic          hilo_sel_q, hilo_sel_d;
  logic          cause_q, cause_d;
  logic          cnt_clr, cnt_en, cnt_tc;

  assign cnt_clr = (state_q == StStart);
  assign cnt_en  = (state_q == StWaitMult) || (state_q == StWaitDiv);

  muldiv_wait_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_cnt (
    .clk_i(clock),
    .rst_i(reset),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .tc_o (cnt_tc)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      hilo_sel_q <= SEL_MULT;
      cause_q    <= CAUSE_TIMEOUT;
    end else begin
      state_q    <= state_d;
      hilo_sel_q <= hilo_sel_d;
      cause_q    <= cause_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    hilo_sel_d = hilo_sel_q;
    cause_d    = cause_q;
    case (state_q)
      StIdle: begin
        if (req && op_mult) begin
          state_d    = StStart;
          hilo_sel_d = SEL_MULT;
        end else if (req && op_div) begin
          state_d    = StStart;
          hilo_sel_d = SEL_DIV;
        end
      end
      StStart: state_d = (hilo_sel_q == SEL_DIV) ? StWaitDiv : StWaitMult;
      StWaitMult: begin
        if (mult_end) begin
          state_d = StWrite;
        end else if (cnt_tc) begin
          state_d = StExc;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      StWaitDiv: begin
        if (div_zero) begin
          state_d = StExc;
          cause_d = CAUSE_DIV_ZERO;
        end else if (div_end) begin
          state_d = StWrite;
        end else if (cnt_tc) begin
          state_d = StExc;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      StExc:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A flushed request is not accepted, so the mux select keeps its old value.
    if (flush) begin
      state_d    = StIdle;
      hilo_sel_d = hilo_sel_q;
    end
  end

  // Moore output decode
  always_comb begin
    start_mult   = 1'b0;
    start_div    = 1'b0;
    wr_high      = 1'b0;
    wr_low       = 1'b0;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    timeout_exc  = 1'b0;
    busy         = (state_q != StIdle);
    hilo_sel     = hilo_sel_q;
    cur_state    = state_q;
    case (state_q)
      StStart: begin
        start_mult = (hilo_sel_q == SEL_MULT);
        start_div  = (hilo_sel_q == SEL_DIV);
      end
      StWrite: begin
        wr_high = 1'b1;
        wr_low  = 1'b1;
      end
      StDone: done = 1'b1;
      StExc: begin
        div_zero_exc = (cause_q == CAUSE_DIV_ZERO);
        timeout_exc  = (cause_q == CAUSE_TIMEOUT);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: table of operations with a reference model that predicts the
// timed output events, checked through a scoreboard, plus per-cycle busy/idle checks.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned T = 8;

  logic       clock = 1'b0;
  logic       reset, req, op_mult, op_div, flush, mult_end, div_end, div_zero;
  logic       start_mult, start_div, hilo_sel, wr_high, wr_low, busy, done;
  logic       div_zero_exc, timeout_exc;
  logic [2:0] cur_state;

  muldiv_sequencer #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (7)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .op_mult     (op_mult),
    .op_div      (op_div),
    .flush       (flush),
    .mult_end    (mult_end),
    .div_end     (div_end),
    .div_zero    (div_zero),
    .start_mult  (start_mult),
    .start_div   (start_div),
    .hilo_sel    (hilo_sel),
    .wr_high     (wr_high),
    .wr_low      (wr_low),
    .busy        (busy),
    .done        (done),
    .div_zero_exc(div_zero_exc),
    .timeout_exc (timeout_exc),
    .cur_state   (cur_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event kinds: 1 start_mult, 2 start_div, 3 write, 4 done, 5 div_zero_exc, 6 timeout_exc
  typedef struct {
    int   kind;
    int   cyc;
    logic sel;
  } ev_t;

  // Delays are relative to the start cycle; 0 means "never".
  typedef struct {
    logic om;
    logic od;
    int   med;
    int   ded;
    int   zd;
    int   fd;
    int   rd;
    int   xd;
  } vec_t;

  ev_t  sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic sel_model = SEL_MULT;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, act, want);
  endtask

  // Monitor: every pulse output must match the next predicted event.
  always @(negedge clock) begin : monitor
    logic [6:0] v;
    int         kind;
    ev_t        e;
    v = {start_mult, start_div, wr_high, wr_low, done, div_zero_exc, timeout_exc};
    if (v != 7'b0) begin
      case (v)
        7'b1000000: kind = 1;
        7'b0100000: kind = 2;
        7'b0011000: kind = 3;
        7'b0000100: kind = 4;
        7'b0000010: kind = 5;
        7'b0000001: kind = 6;
        default:    kind = 7;
      endcase
      if (sb.size() == 0) begin
        check("unexpected_event", kind, 0);
      end else begin
        e = sb.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        check("event_sel", int'(hilo_sel), int'(e.sel));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   c0, s, w, e, a, t, dly, kind;
    logic valid, sel, is_div, hit;
    ev_t  evs[$];
    @(negedge clock);
    c0     = cyc;
    s      = c0 + 1;
    w      = s + 1;
    e      = c0;
    valid  = v.om | v.od;
    is_div = !v.om && v.od;
    sel    = is_div ? SEL_DIV : SEL_MULT;
    if (valid) begin
      evs.push_back('{is_div ? 2 : 1, s, sel});
      dly = is_div ? v.ded : v.med;
      hit = 1'b0;
      kind = 0;
      for (int c = w; c <= w + int'(T) - 1; c++) begin
        if (!hit) begin
          if (is_div && v.zd > 0 && c == s + v.zd) begin
            hit = 1'b1; kind = 5; t = c;
          end else if (dly > 0 && c == s + dly) begin
            hit = 1'b1; kind = 3; t = c;
          end else if (c == w + int'(T) - 1) begin
            hit = 1'b1; kind = 6; t = c;
          end
        end
      end
      if (kind == 3) begin
        evs.push_back('{3, t + 1, sel});
        evs.push_back('{4, t + 2, sel});
        e = t + 2;
      end else begin
        evs.push_back('{kind, t + 1, sel});
        e = t + 1;
      end
      sel_model = sel;
    end
    a = 1 << 30;
    if (v.fd > 0) a = s + v.fd;
    if (v.rd > 0 && s + v.rd < a) a = s + v.rd;
    foreach (evs[i]) if (evs[i].cyc <= a) sb.push_back(evs[i]);
    if (a < e) e = a;
    if (v.rd > 0) sel_model = SEL_MULT;

    req     = 1'b1;
    op_mult = v.om;
    op_div  = v.od;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        @(negedge clock);
        t        = cyc;
        req      = (v.xd > 0 && t == s + v.xd);
        op_mult  = req;
        op_div   = req;
        mult_end = (v.med > 0 && t == s + v.med);
        div_end  = (v.ded > 0 && t == s + v.ded);
        div_zero = (v.zd > 0 && t == s + v.zd);
        flush    = (v.fd > 0 && t == s + v.fd);
        reset    = (v.rd > 0 && t == s + v.rd);
      end
      t = cyc;
      check("busy", int'(busy), int'(t >= s && t <= e));
      if (t == e + 1) begin
        check("idle_state", int'(cur_state), int'(StIdle));
        check("idle_outputs", int'({start_mult, start_div, wr_high, wr_low, done,
                                    div_zero_exc, timeout_exc, busy}), 0);
        check("hilo_sel_hold", int'(hilo_sel), int'(sel_model));
      end
    end
    {req, op_mult, op_div, mult_end, div_end, div_zero, flush, reset} = '0;
    check("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  vec_t vecs[17];

  initial begin
    //          om  od  med ded zd fd rd xd
    vecs[0]  = '{1, 0,  3,  0,  0, 0, 0, 0};  // mult, end 3 after start
    vecs[1]  = '{0, 1,  0,  1,  0, 0, 0, 0};  // div, minimum latency
    vecs[2]  = '{1, 0,  1,  0,  0, 0, 0, 0};  // mult, minimum latency
    vecs[3]  = '{0, 1,  0,  0,  1, 0, 0, 0};  // div by zero
    vecs[4]  = '{0, 1,  0,  0,  0, 0, 0, 0};  // div timeout
    vecs[5]  = '{1, 1,  2,  0,  0, 0, 0, 1};  // both ops, second req while waiting
    vecs[6]  = '{0, 1,  0,  5,  0, 2, 0, 0};  // flush in WAIT_DIV
    vecs[7]  = '{1, 0,  2,  0,  0, 3, 0, 0};  // flush in WRITE
    vecs[8]  = '{1, 0,  6,  0,  0, 0, 2, 0};  // reset in WAIT_MULT, late mult_end
    vecs[9]  = '{0, 1,  0,  4,  0, 0, 1, 0};  // reset in WAIT_DIV clears hilo_sel
    vecs[10] = '{1, 0,  8,  0,  0, 0, 0, 0};  // end on the last cycle before timeout
    vecs[11] = '{1, 0,  9,  0,  0, 0, 0, 0};  // end one cycle too late
    vecs[12] = '{0, 1,  0,  3,  3, 0, 0, 0};  // div_zero beats div_end
    vecs[13] = '{0, 1,  2,  5,  0, 0, 0, 0};  // mult_end ignored while dividing
    vecs[14] = '{0, 0,  2,  0,  0, 0, 0, 0};  // req with no op is ignored
    vecs[15] = '{1, 0,  4,  2,  2, 0, 0, 0};  // div flags ignored while multiplying
    vecs[16] = '{0, 1,  0,  3,  0, 3, 3, 0};  // flush with reset: reset wins

    {req, op_mult, op_div, mult_end, div_end, div_zero, flush} = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_state", int'(cur_state), int'(StIdle));
    check("reset_outputs", int'({start_mult, start_div, hilo_sel, wr_high, wr_low, busy, done,
                                 div_zero_exc, timeout_exc}), 0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
